// File: rtl/char_digit_renderer_if.sv
// Signal bundle for char_digit_renderer: digit buffer controls, incoming pixel
// coordinates, the glyph ROM port and the outgoing pixel.
//
// Qualifier semantics: there is no back-pressure anywhere on this bundle.
// pix_de qualifies pix_x/pix_y in the cycle they are presented. pix_valid
// qualifies pix_rgb in the cycle it is presented, exactly three clocks later.
// frame_start and digits_load are single-cycle strobes. rom_q answers
// rom_address/rom_digit one clock after they are presented.
interface char_digit_renderer_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      frame_start;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic                      digits_load;
  logic                      pix_de;
  logic [10:0]               pix_x;
  logic [10:0]               pix_y;
  logic [6:0]                rom_address;
  logic [3:0]                rom_digit;
  logic                      rom_q;
  logic                      pix_valid;
  logic [15:0]               pix_rgb;
  logic                      update_pending;

  // Master: timing generator, digit source and glyph ROMs.
  modport master (
    output frame_start, digits_in, digits_load, pix_de, pix_x, pix_y, rom_q,
    input  rom_address, rom_digit, pix_valid, pix_rgb, update_pending
  );

  // Slave: the renderer itself.
  modport slave (
    input  frame_start, digits_in, digits_load, pix_de, pix_x, pix_y, rom_q,
    output rom_address, rom_digit, pix_valid, pix_rgb, update_pending
  );
endinterface

// File: rtl/char_digit_renderer.sv
// Renders a row of BCD digits at a fixed screen position from 8x16 glyph
// ROMs. The pipeline is three stages: window/address decode, ROM read, and
// colour select. Digit updates are double-buffered and only swap in at
// frame_start.
module char_digit_renderer #(
  parameter logic [10:0] X0          = 11'd100,
  parameter logic [10:0] Y0          = 11'd100,
  parameter int          NUM_DIGITS  = 4,
  parameter int          SCALE_SHIFT = 0,
  parameter logic [15:0] FG_COLOR    = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  char_digit_renderer_if.slave  bus
);

  localparam int X_END_I = int'(X0) + ((NUM_DIGITS * 8) << SCALE_SHIFT);
  localparam int Y_END_I = int'(Y0) + (16 << SCALE_SHIFT);
  localparam logic [10:0] X_END = 11'(X_END_I);
  localparam logic [10:0] Y_END = 11'(Y_END_I);

  generate
    if (X_END_I > 2047 || Y_END_I > 2047) begin : g_bad_window
      $error("char_digit_renderer: digit field extends past coordinate 2047");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("char_digit_renderer: NUM_DIGITS must be 1..8");
    end
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 2) begin : g_bad_scale
      $error("char_digit_renderer: SCALE_SHIFT must be 0..2");
    end
  endgenerate

  logic [4*NUM_DIGITS-1:0] active_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic                    pending_flag;

  // Stage 0 decode results
  logic        in_win_s0;
  logic [10:0] dx;
  logic [3:0]  row;
  logic [7:0]  idx;
  logic [3:0]  code_s0;
  logic        blank_s0;
  logic [6:0]  addr_s0;
  logic [3:0]  digit_s0;

  // Stage 1/2 registers
  logic [6:0]  rom_address_r;
  logic [3:0]  rom_digit_r;
  logic        de_d1, win_d1, blank_d1;
  logic        de_d2, win_d2, blank_d2;

  // Stage 3 registers
  logic        pix_valid_r;
  logic [15:0] pix_rgb_r;

  // Double buffer: a simultaneous load and frame_start bypasses straight to active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_reg   <= '1;
      pending_reg  <= '1;
      pending_flag <= 1'b0;
    end else if (bus.digits_load && bus.frame_start) begin
      active_reg   <= bus.digits_in;
      pending_reg  <= bus.digits_in;
      pending_flag <= 1'b0;
    end else if (bus.digits_load) begin
      pending_reg  <= bus.digits_in;
      pending_flag <= 1'b1;
    end else if (bus.frame_start && pending_flag) begin
      active_reg   <= pending_reg;
      pending_flag <= 1'b0;
    end
  end

  // Window test and glyph address; offsets are only formed once inside the window.
  always_comb begin
    in_win_s0 = bus.pix_de &&
                (bus.pix_x >= X0) && (bus.pix_x < X_END) &&
                (bus.pix_y >= Y0) && (bus.pix_y < Y_END);
    dx  = in_win_s0 ? ((bus.pix_x - X0) >> SCALE_SHIFT) : 11'd0;
    row = in_win_s0 ? 4'((bus.pix_y - Y0) >> SCALE_SHIFT) : 4'd0;
    idx = dx[10:3];
    code_s0 = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 8'(i)) code_s0 = active_reg[4*(NUM_DIGITS-1-i) +: 4];
    end
    blank_s0 = (code_s0 > 4'd9);
    addr_s0  = 7'd0;
    digit_s0 = 4'd0;
    if (in_win_s0 && !blank_s0) begin
      addr_s0  = {row, dx[2:0]};
      digit_s0 = code_s0;
    end
  end

  // Stage 1 (ROM address) and stage 2 (flags aligned with rom_q).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_address_r <= 7'd0;
      rom_digit_r   <= 4'd0;
      de_d1         <= 1'b0;
      win_d1        <= 1'b0;
      blank_d1      <= 1'b0;
      de_d2         <= 1'b0;
      win_d2        <= 1'b0;
      blank_d2      <= 1'b0;
    end else begin
      rom_address_r <= addr_s0;
      rom_digit_r   <= digit_s0;
      de_d1         <= bus.pix_de;
      win_d1        <= in_win_s0;
      blank_d1      <= blank_s0;
      de_d2         <= de_d1;
      win_d2        <= win_d1;
      blank_d2      <= blank_d1;
    end
  end

  // Stage 3: colour select from the registered ROM bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_valid_r <= 1'b0;
      pix_rgb_r   <= 16'h0000;
    end else begin
      pix_valid_r <= de_d2;
      if (!de_d2)                  pix_rgb_r <= 16'h0000;
      else if (!win_d2 || blank_d2) pix_rgb_r <= BG_COLOR;
      else if (bus.rom_q)          pix_rgb_r <= FG_COLOR;
      else                         pix_rgb_r <= BG_COLOR;
    end
  end

  assign bus.rom_address    = rom_address_r;
  assign bus.rom_digit      = rom_digit_r;
  assign bus.pix_valid      = pix_valid_r;
  assign bus.pix_rgb        = pix_rgb_r;
  assign bus.update_pending = pending_flag;

endmodule

// File: doc/char_digit_renderer.md
# char_digit_renderer

Pixel-stream stage that drives the 8x16 glyph ROMs (one per digit 0-9, 7-bit address, 1-bit registered output) and turns their bits into RGB565 pixels for the TFT. It sits between the TFT timing generator, which supplies DE/x/y, and the panel output register. It renders a row of BCD digits at a fixed screen position. Digit updates are double-buffered and only take effect at frame start, so a frame never shows a mix of old and new digits.

## Interface
- X0, 11'd100: left pixel column of the digit field
- Y0, 11'd100: top pixel row of the digit field
- NUM_DIGITS, 4: digits shown, 1..8
- SCALE_SHIFT, 0: glyph magnification 2^SCALE_SHIFT, range 0..2
- FG_COLOR, 16'hFFFF: RGB565 colour for a set glyph bit
- BG_COLOR, 16'h0000: RGB565 colour inside the field for a clear bit or a blank digit

- clock  in  1  system/pixel clock; every register updates on its rising edge
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse from the timing generator at the first pixel of each frame
- digits_in  in  4*NUM_DIGITS  BCD value; the most-significant nibble is the leftmost digit
- digits_load  in  1  one-cycle strobe that captures digits_in into the pending buffer
- pix_de  in  1  data-enable for the current pixel
- pix_x, pix_y  in  11 each  coordinates of the current pixel
- rom_address  out  7  glyph ROM address, computed as row*8 + col
- rom_digit  out  4  selects which digit ROM's q is routed to rom_q
- rom_q  in  1  selected ROM output; valid one clock after rom_address/rom_digit
- pix_valid  out  1  delayed copy of pix_de
- pix_rgb  out  16  output pixel
- update_pending  out  1  high while a loaded value is waiting for frame_start

## Operation
- Buffers:
  - pending_reg is written by digits_load and sets pending_flag.
  - On frame_start with pending_flag set, active_reg <= pending_reg and pending_flag is cleared.
  - If digits_load and frame_start arrive in the same cycle, digits_in goes straight into active_reg and pending_flag ends low.
  - Several loads before one frame_start: the last load wins.
  - update_pending = pending_flag.
- Window test, evaluated in stage 0:
  - pix_x in [X0, X0 + NUM_DIGITS*8<<S)
  - pix_y in [Y0, Y0 + 16<<S)
  - pix_de = 1
- Inside the window:
  - dx = (pix_x-X0)>>S and dy = (pix_y-Y0)>>S
  - col = dx[2:0], idx = dx>>3, row = dy[3:0]
  - code = nibble idx of active_reg, where idx 0 is the leftmost digit
- Codes 10-15 are blank: the pixel shows BG_COLOR and the ROM bit is ignored.
- Outside the window, or for a blank code, rom_address and rom_digit are driven to 0.
- Stage-0 flags (de, in_window, blank) travel through a two-deep shift pipeline to line up with rom_q.
- Output register:
  - pix_valid = de_d2
  - pix_rgb = 0 when de_d2 = 0
  - otherwise BG_COLOR when outside the window or blank
  - otherwise FG_COLOR if rom_q = 1, else BG_COLOR
- All arithmetic is unsigned 11-bit.
- Subtraction is performed only after the compare has passed, so there is no wrap below X0/Y0.
- The window end is computed at elaboration; it must be <= 2047, enforced by an elaboration check.

## Timing
- E1, the first clock edge after the inputs are sampled in cycle T: rom_address, rom_digit and the stage-1 flags register.
- E2: the ROM registers q; rom_q is valid during cycle T+2.
- E3: pix_valid and pix_rgb register.
- Fixed latency is 3 clocks, fully pipelined at one pixel per clock, with no stalls and no back-pressure.
- An active_reg swap at frame_start affects pixels sampled from the next cycle onward. The first pixel of the frame is sampled together with frame_start and still uses the old value; this is acceptable because the field never starts at (0,0).
- Reset values:
  - rom_address = 0, rom_digit = 0
  - pix_valid = 0, pix_rgb = 0
  - update_pending = 0
  - active_reg and pending_reg all 4'hF, so every digit is blank
  - pipeline flags all 0
- Reset asserted mid-frame clears everything immediately. Output stays pix_valid = 0 until 3 clocks after reset is released while pix_de is high.

## Test plan
- Reset, then load 16'h0007 and pulse frame_start; scan the 8x16 cell of digit 3 at S=0:
  - rom_digit = 7 and rom_address = row*8 + col
  - pix_rgb matches the ROM bitmap, e.g. row 3 cols 1-6 = FFFF
  - pixels appear exactly 3 clocks after the inputs
- Before any load, scan the whole field: every pixel = BG_COLOR with pix_valid = 1; outside the field pix_rgb = BG_COLOR and valid follows pix_de.
- Load 16'h1234 mid-frame: the current frame is unchanged, update_pending = 1; after frame_start the next frame shows 1234 and update_pending = 0.
- Pulse digits_load and frame_start in the same cycle with 16'h9999: active = 9999 and update_pending stays 0; two loads (1111 then 2222) before frame_start show 2222.
- SCALE_SHIFT = 1: the pixel at (X0+3, Y0+5) maps to col 1, row 2. Codes A-F in digits_in render as BG, and x = X0-1 and x = X0+64 are outside the field.
- Assert reset during an active line: pix_valid drops to 0 the same cycle, all digits show blank afterwards, and the pipeline refills with 3-clock latency.
